// File: rtl/risc_lsu_if.sv
// Request, data-memory bus and response signals of the load/store unit.
// The LSU binds to the slave view; the execute stage / memory side uses master.
interface risc_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [2:0]          req_funct3;
    logic [ADDR_W-1:0]   req_addr;
    logic [XLEN-1:0]     req_wdata;

    logic                mem_valid;
    logic                mem_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN/8-1:0]   mem_be;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN-1:0]     mem_rdata;

    logic                rsp_valid;
    logic [XLEN-1:0]     rsp_rdata;
    logic                rsp_err;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output req_ready, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/risc_lsu.sv
// Load/store unit: one request at a time, misaligned accesses split into two
// aligned byte-enabled beats, load data gathered and sign/zero extended.
module risc_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    risc_lsu_if.slave   bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int BW    = 2 * NB;

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

    state_t            r_state, w_state_next;
    logic              r_we, r_uns, r_rsp_err;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata, r_lo, r_rsp_rdata;

    logic              w_accept, w_legal, w_done, w_split, w_sign;
    logic [OFF_W-1:0]  w_off;
    logic [3:0]        w_nbytes;
    logic [4:0]        w_span;
    logic [ADDR_W-1:0] w_aligned;
    logic [BW-1:0]     w_be_win;
    logic [2*XLEN-1:0] w_wd_win, w_rd_win, w_rd_shift;
    logic [XLEN-1:0]   w_gather, w_mask, w_ext;

    function automatic logic f_legal(input logic we, input logic [2:0] f3);
        if (we)
            return !f3[2] && ((XLEN == 64) || (f3 != 3'b011));
        else
            return (f3 != 3'b111) && ((XLEN == 64) || ((f3 != 3'b011) && (f3 != 3'b110)));
    endfunction

    assign w_accept  = bus.req_valid && (r_state == S_IDLE);
    assign w_legal   = f_legal(bus.req_we, bus.req_funct3);
    assign w_done    = bus.mem_valid && bus.mem_ready;
    assign w_off     = r_addr[OFF_W-1:0];
    assign w_nbytes  = 4'd1 << r_size;
    assign w_span    = 5'(w_off) + 5'(w_nbytes);
    assign w_split   = w_span > 5'(NB);
    assign w_aligned = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Both beats are viewed as one double-width window: low half is beat0, high half beat1.
    assign w_be_win   = ((BW'(1) << w_nbytes) - BW'(1)) << w_off;
    assign w_wd_win   = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
    assign w_rd_win   = (r_state == S_BEAT1) ? {bus.mem_rdata, r_lo} : {{XLEN{1'b0}}, bus.mem_rdata};
    assign w_rd_shift = w_rd_win >> {w_off, 3'b000};
    assign w_gather   = w_rd_shift[XLEN-1:0];

    always_comb begin
        w_mask = '1;
        w_sign = w_gather[XLEN-1];
        case (r_size)
            2'd0: begin w_mask = XLEN'(8'hFF);         w_sign = w_gather[7];  end
            2'd1: begin w_mask = XLEN'(16'hFFFF);      w_sign = w_gather[15]; end
            2'd2: begin w_mask = XLEN'(32'hFFFF_FFFF); w_sign = w_gather[31]; end
            default: ;
        endcase
        w_ext = (w_gather & w_mask) | ((!r_uns && w_sign) ? ~w_mask : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = w_legal ? S_BEAT0 : S_RESP;
            S_BEAT0: if (bus.mem_ready) w_state_next = w_split ? S_BEAT1 : S_RESP;
            S_BEAT1: if (bus.mem_ready) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (r_state == S_IDLE);
        bus.mem_valid = (r_state == S_BEAT0) || (r_state == S_BEAT1);
        bus.mem_we    = bus.mem_valid && r_we;
        bus.mem_addr  = '0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
        if (r_state == S_BEAT0) begin
            bus.mem_addr  = w_aligned;
            bus.mem_be    = w_be_win[NB-1:0];
            bus.mem_wdata = w_wd_win[XLEN-1:0];
        end else if (r_state == S_BEAT1) begin
            bus.mem_addr  = w_aligned + ADDR_W'(NB);
            bus.mem_be    = w_be_win[BW-1:NB];
            bus.mem_wdata = w_wd_win[2*XLEN-1:XLEN];
        end
        bus.rsp_valid = (r_state == S_RESP);
        bus.rsp_rdata = r_rsp_rdata;
        bus.rsp_err   = r_rsp_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_size      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_lo        <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_size  <= bus.req_funct3[1:0];
                r_uns   <= bus.req_funct3[2];
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                if (!w_legal) begin
                    r_rsp_err   <= 1'b1;
                    r_rsp_rdata <= '0;
                end
            end
            if ((r_state == S_BEAT0) && w_done)
                r_lo <= bus.mem_rdata;
            // The last beat of an access latches the response for the RESP cycle.
            if (w_done && ((r_state == S_BEAT1) || !w_split)) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= r_we ? '0 : w_ext;
            end
        end
    end
endmodule

// File: tb/tb_risc_lsu.sv
// Scoreboard bench for risc_lsu (XLEN=32): expected beats and responses are
// queued when a request is driven and consumed as the unit produces them.
module tb_risc_lsu;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    risc_lsu_if #(.XLEN(32), .ADDR_W(32)) bus();
    risc_lsu #(.XLEN(32), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } rsp_t;

    beat_t exp_beats[$];
    rsp_t  exp_rsp[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_beat(input logic [31:0] addr, input logic [3:0] be, input logic we,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        beat_t b;
        b.addr = addr; b.be = be; b.we = we; b.wdata = wdata; b.rdata = rdata; b.waits = waits;
        exp_beats.push_back(b);
    endtask

    // Memory responder: checks every cycle of each beat, which also covers stability under stalls.
    always @(negedge clk) begin
        if (bus.mem_valid) begin
            check_val("busy_req_ready", 64'(bus.req_ready), 64'(0));
            if (exp_beats.size() == 0) begin
                check_val("beat_unexpected", 64'(bus.mem_valid), 64'(0));
                bus.mem_ready = 1'b1;
                bus.mem_rdata = $urandom;
            end else begin
                check_val("beat_addr", 64'(bus.mem_addr), 64'(exp_beats[0].addr));
                check_val("beat_be",   64'(bus.mem_be),   64'(exp_beats[0].be));
                check_val("beat_we",   64'(bus.mem_we),   64'(exp_beats[0].we));
                if (exp_beats[0].we)
                    check_val("beat_wdata", 64'(bus.mem_wdata), 64'(exp_beats[0].wdata));
                if (exp_beats[0].waits > 0) begin
                    exp_beats[0].waits = exp_beats[0].waits - 1;
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                end else begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = exp_beats[0].rdata;
                    void'(exp_beats.pop_front());
                end
            end
        end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
        end
    end

    // Response monitor: latency counted with the accept edge as T.
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                check_val("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
            end else begin
                rsp_t r;
                r = exp_rsp.pop_front();
                check_val("rsp_rdata",   64'(bus.rsp_rdata), 64'(r.rdata));
                check_val("rsp_err",     64'(bus.rsp_err),   64'(r.err));
                check_val("rsp_latency", 64'(cyc - r.acc + 1), 64'(r.lat));
                $display("txn rsp rdata=0x%08h err=%0d latency=%0d", bus.rsp_rdata, bus.rsp_err, cyc - r.acc + 1);
            end
        end
    end

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input int lat, input int hold);
        rsp_t r;
        int   k;
        @(negedge clk);
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val("req_ready_idle", 64'(bus.req_ready), 64'(1));
        r.rdata = exp_rdata; r.err = exp_err; r.lat = lat; r.acc = cyc + 1;
        exp_rsp.push_back(r);
        $display("txn req we=%0d funct3=%03b addr=0x%08h wdata=0x%08h", we, f3, addr, wdata);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        // A different request held while busy must be ignored entirely.
        for (int i = 0; i < hold; i++) begin
            bus.req_we     = 1'b0;
            bus.req_funct3 = 3'b010;
            bus.req_addr   = 32'h0000_0300;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        k = 0;
        while (exp_rsp.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val("rsp_timeout", 64'(exp_rsp.size()), 64'(0));
        check_val("beats_left",  64'(exp_beats.size()), 64'(0));
        exp_rsp.delete();
        exp_beats.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;

        #12;
        check_val("rst_req_ready", 64'(bus.req_ready), 64'(1));
        check_val("rst_mem_valid", 64'(bus.mem_valid), 64'(0));
        check_val("rst_mem_we",    64'(bus.mem_we),    64'(0));
        check_val("rst_mem_addr",  64'(bus.mem_addr),  64'(0));
        check_val("rst_mem_be",    64'(bus.mem_be),    64'(0));
        check_val("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_val("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        check_val("rst_rsp_err",   64'(bus.rsp_err),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned LW, then confirm the response data holds afterwards.
        add_beat(32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 0);
        run_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
        repeat (3) @(negedge clk);
        check_val("rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(32'hDEADBEEF));

        add_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80000000, 0);
        run_req(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0);
        add_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80000000, 0);
        run_req(1'b0, 3'b100, 32'h103, 32'h0, 32'h00000080, 1'b0, 2, 0);

        // Misaligned LW split across two beats.
        add_beat(32'h100, 4'b1100, 1'b0, 32'h0, 32'hBBAA0000, 0);
        add_beat(32'h104, 4'b0011, 1'b0, 32'h0, 32'h0000DDCC, 0);
        run_req(1'b0, 3'b010, 32'h102, 32'h0, 32'hDDCCBBAA, 1'b0, 3, 0);

        add_beat(32'h0FC, 4'b1000, 1'b1, 32'h34000000, 32'h0, 0);
        add_beat(32'h100, 4'b0001, 1'b1, 32'h00000012, 32'h0, 0);
        run_req(1'b1, 3'b001, 32'h0FF, 32'h00001234, 32'h0, 1'b0, 3, 0);

        // Stalled SW with an ignored request presented while busy.
        add_beat(32'h200, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h0, 3);
        run_req(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0, 1'b0, 5, 2);

        run_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0);
        run_req(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0);

        add_beat(32'h104, 4'b1100, 1'b0, 32'h0, 32'h9A8B0000, 0);
        run_req(1'b0, 3'b001, 32'h106, 32'h0, 32'hFFFF9A8B, 1'b0, 2, 0);
        add_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h12000000, 0);
        add_beat(32'h104, 4'b0001, 1'b0, 32'h0, 32'h000000F3, 0);
        run_req(1'b0, 3'b101, 32'h103, 32'h0, 32'h0000F312, 1'b0, 3, 0);
        add_beat(32'h100, 4'b0010, 1'b1, 32'h0000A500, 32'h0, 0);
        run_req(1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1'b0, 2, 0);

        // Second beat address wraps past the top of the address space.
        add_beat(32'hFFFFFFFC, 4'b1100, 1'b0, 32'h0, 32'h56780000, 0);
        add_beat(32'h00000000, 4'b0011, 1'b0, 32'h0, 32'h00001234, 0);
        run_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h12345678, 1'b0, 3, 0);

        // Reset asserted during beat0 of a split load: no response may follow.
        add_beat(32'h100, 4'b1100, 1'b0, 32'h0, 32'h0, 1000);
        @(negedge clk);
        $display("txn req we=0 funct3=010 addr=0x00000102 (aborted by reset)");
        bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h102; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_val("abort_mem_valid_before", 64'(bus.mem_valid), 64'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_beats.delete();
        check_val("abort_mem_valid", 64'(bus.mem_valid), 64'(0));
        check_val("abort_mem_be",    64'(bus.mem_be),    64'(0));
        check_val("abort_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("abort_req_ready", 64'(bus.req_ready), 64'(1));
        check_val("abort_idle_mem",  64'(bus.mem_valid), 64'(0));

        // Unit still works after the abort.
        add_beat(32'h100, 4'b1111, 1'b0, 32'h0, 32'h01234567, 0);
        run_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h01234567, 1'b0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
